// File: rtl/ysyx_22040931_div_ctrl_pkg.sv
// Shared types and constants for the divider sequencing controller.
// Holds the FSM state encoding, the most-negative operands and the W-op extension helpers.
package ysyx_22040931_div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  localparam logic [63:0] DIV_MOST_NEG_64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] DIV_MOST_NEG_32 = 32'h8000_0000;

  function automatic logic [63:0] sext_w(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Effective 64-bit operand of a W op: sign- or zero-extended low word.
  function automatic logic [63:0] w_operand(input logic [31:0] v, input logic sgn);
    return sgn ? sext_w(v) : {32'h0, v};
  endfunction

endpackage

// File: rtl/ysyx_22040931_div_ctrl_if.sv
// Request, response and divider-side signals of the divider controller.
// slave is the controller's view; master is the surrounding pipeline/divider view.
interface ysyx_22040931_div_ctrl_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            in_rem;
  logic            in_w;
  logic            in_signed;
  logic [XLEN-1:0] in_dividend;
  logic [XLEN-1:0] in_divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            div_start;
  logic            div_kill;
  logic            div_w;
  logic            div_signed;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_done;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;

  modport slave (
    input  in_valid, in_rem, in_w, in_signed, in_dividend, in_divisor,
    input  out_ready, div_done, div_quotient, div_remainder,
    output in_ready, out_valid, out_result,
    output div_start, div_kill, div_w, div_signed, div_dividend, div_divisor
  );

  modport master (
    output in_valid, in_rem, in_w, in_signed, in_dividend, in_divisor,
    output out_ready, div_done, div_quotient, div_remainder,
    input  in_ready, out_valid, out_result,
    input  div_start, div_kill, div_w, div_signed, div_dividend, div_divisor
  );
endinterface

// File: rtl/ysyx_22040931_div_special.sv
// Combinational classifier for RISC-V division corner cases (divide-by-zero, signed overflow).
// Operands arrive already extended for W ops; results are pre-W-fixup.
module ysyx_22040931_div_special
  import ysyx_22040931_div_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            w_i,
  input  logic            signed_i,
  output logic            is_zero_o,
  output logic            is_ovf_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic ovf32;
  logic ovf64;

  assign is_zero_o = (divisor_i == '0);
  assign ovf32     = (dividend_i[31:0] == DIV_MOST_NEG_32) && (divisor_i[31:0] == '1);
  assign ovf64     = (dividend_i == DIV_MOST_NEG_64) && (divisor_i == '1);
  assign is_ovf_o  = signed_i && !is_zero_o && (w_i ? ovf32 : ovf64);

  // Overflow quotient is the dividend itself; the remainder is zero.
  assign quo_o = is_zero_o ? '1 : dividend_i;
  assign rem_o = is_zero_o ? dividend_i : '0;

endmodule

// File: rtl/ysyx_22040931_div_ctrl.sv
// Sequencing controller in front of the iterative divider: resolves corner cases and cache hits
// in one cycle, otherwise starts the divider and waits for completion; flush aborts in-flight work.
module ysyx_22040931_div_ctrl
  import ysyx_22040931_div_ctrl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  ysyx_22040931_div_ctrl_if.slave       bus
);

  div_state_e      state_q;
  logic            rem_q;
  logic            div_w_q;
  logic            div_signed_q;
  logic [XLEN-1:0] div_dvd_q;
  logic [XLEN-1:0] div_dvs_q;
  logic [XLEN-1:0] out_result_q;

  logic            c_vld_q;
  logic            c_w_q;
  logic            c_sgn_q;
  logic [XLEN-1:0] c_dvd_q;
  logic [XLEN-1:0] c_dvs_q;
  logic [XLEN-1:0] c_quo_q;
  logic [XLEN-1:0] c_rem_q;

  logic [XLEN-1:0] dvd_eff;
  logic [XLEN-1:0] dvs_eff;
  logic            is_zero;
  logic            is_ovf;
  logic [XLEN-1:0] sp_quo;
  logic [XLEN-1:0] sp_rem;
  logic            hit;
  logic            fast;
  logic            in_ready;
  logic            accept;
  logic [XLEN-1:0] fast_result_d;
  logic [XLEN-1:0] done_result_d;

  function automatic logic [XLEN-1:0] w_fix(input logic w, input logic [XLEN-1:0] v);
    return w ? sext_w(v[31:0]) : v;
  endfunction

  assign dvd_eff = bus.in_w ? w_operand(bus.in_dividend[31:0], bus.in_signed) : bus.in_dividend;
  assign dvs_eff = bus.in_w ? w_operand(bus.in_divisor[31:0], bus.in_signed) : bus.in_divisor;

  ysyx_22040931_div_special #(.XLEN(XLEN)) u_special (
    .dividend_i (dvd_eff),
    .divisor_i  (dvs_eff),
    .w_i        (bus.in_w),
    .signed_i   (bus.in_signed),
    .is_zero_o  (is_zero),
    .is_ovf_o   (is_ovf),
    .quo_o      (sp_quo),
    .rem_o      (sp_rem)
  );

  assign hit = CACHE_EN && c_vld_q && (dvd_eff == c_dvd_q) && (dvs_eff == c_dvs_q)
               && (bus.in_w == c_w_q) && (bus.in_signed == c_sgn_q);
  assign fast = is_zero || is_ovf || hit;

  // Corner cases take precedence over the cache so a stale entry can never mask them.
  assign fast_result_d = w_fix(bus.in_w, bus.in_rem ? ((is_zero || is_ovf) ? sp_rem : c_rem_q)
                                                    : ((is_zero || is_ovf) ? sp_quo : c_quo_q));
  assign done_result_d = w_fix(div_w_q, rem_q ? bus.div_remainder : bus.div_quotient);

  assign in_ready = !reset && !flush
                    && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_q == S_DONE);
  assign bus.out_result   = out_result_q;
  assign bus.div_start    = (state_q == S_START) && !flush;
  assign bus.div_kill     = flush && ((state_q == S_START) || (state_q == S_BUSY));
  assign bus.div_w        = div_w_q;
  assign bus.div_signed   = div_signed_q;
  assign bus.div_dividend = div_dvd_q;
  assign bus.div_divisor  = div_dvs_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rem_q        <= 1'b0;
      div_w_q      <= 1'b0;
      div_signed_q <= 1'b0;
      div_dvd_q    <= '0;
      div_dvs_q    <= '0;
      out_result_q <= '0;
      c_vld_q      <= 1'b0;
      c_w_q        <= 1'b0;
      c_sgn_q      <= 1'b0;
      c_dvd_q      <= '0;
      c_dvs_q      <= '0;
      c_quo_q      <= '0;
      c_rem_q      <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            rem_q        <= bus.in_rem;
            div_w_q      <= bus.in_w;
            div_signed_q <= bus.in_signed;
            div_dvd_q    <= dvd_eff;
            div_dvs_q    <= dvs_eff;
            if (fast) begin
              out_result_q <= fast_result_d;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_START;
            end
          end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_START: state_q <= S_BUSY;
        S_BUSY: begin
          if (bus.div_done) begin
            out_result_q <= done_result_d;
            c_vld_q      <= 1'b1;
            c_w_q        <= div_w_q;
            c_sgn_q      <= div_signed_q;
            c_dvd_q      <= div_dvd_q;
            c_dvs_q      <= div_dvs_q;
            c_quo_q      <= bus.div_quotient;
            c_rem_q      <= bus.div_remainder;
            state_q      <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_div_ctrl.sv
// Bench for the divider controller: a stub divider with programmable latency and a result
// scoreboard fed at request time and drained when the controller presents a result.
module tb_ysyx_22040931_div_ctrl;

  logic clock;
  logic reset;
  logic flush;
  int   cyc;
  int   checks;
  int   errors;
  int   stub_lat;
  int   start_cnt;
  int   start_cyc;
  int   done_cyc;
  logic [63:0] sb[$];

  typedef struct {
    bit          rem;
    bit          w;
    bit          sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } sp_t;

  ysyx_22040931_div_ctrl_if #(.XLEN(64)) bus ();

  ysyx_22040931_div_ctrl #(.XLEN(64), .CACHE_EN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RISC-V M-extension reference for all division flavours, including corner cases.
  function automatic logic [63:0] ref_div(input bit rem, input bit w, input bit sgn,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, s32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'h0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 32'h0; end
      else if (sgn) begin q32 = 32'($signed(a32) / $signed(b32)); r32 = 32'($signed(a32) % $signed(b32)); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      s32 = rem ? r32 : q32;
      return {{32{s32[31]}}, s32};
    end
    if (b == 64'h0) begin q = '1; r = a; end
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 64'h0; end
    else if (sgn) begin q = 64'($signed(a) / $signed(b)); r = 64'($signed(a) % $signed(b)); end
    else begin q = a / b; r = a % b; end
    return rem ? r : q;
  endfunction

  // Stub divider: answers stub_lat cycles after the start pulse and ignores div_kill.
  initial begin : stub
    int l;
    logic [63:0] a, b;
    bit w, s;
    start_cnt = 0; start_cyc = -1; done_cyc = -1;
    bus.div_done = 1'b0; bus.div_quotient = '0; bus.div_remainder = '0;
    forever begin
      @(negedge clock);
      bus.div_done = 1'b0;
      if (bus.div_start === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
        l = stub_lat;
        a = bus.div_dividend; b = bus.div_divisor; w = bus.div_w; s = bus.div_signed;
        repeat (l) @(negedge clock);
        bus.div_quotient  = ref_div(1'b0, w, s, a, b);
        bus.div_remainder = ref_div(1'b1, w, s, a, b);
        bus.div_done      = 1'b1;
        done_cyc          = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input bit rem, input bit w, input bit sgn,
                       input logic [63:0] a, input logic [63:0] b, output int acc);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_rem = rem; bus.in_w = w; bus.in_signed = sgn;
    bus.in_dividend = a; bus.in_divisor = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL issue_timeout: in_ready=%b required 1", bus.in_ready); end
    acc = cyc;
    sb.push_back(ref_div(rem, w, sgn, a, b));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int oc);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL out_timeout: out_valid=%b required 1", bus.out_valid); end
    oc = cyc;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.div_start, bus.div_kill} !== 4'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b required 0000",
                               {bus.in_ready, bus.out_valid, bus.div_start, bus.div_kill}); end
    checks++;
    if (bus.out_result !== 64'h0 || bus.div_dividend !== 64'h0)
      begin errors++; $display("FAIL reset_data: result %h dividend %h required 0", bus.out_result, bus.div_dividend); end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_idle: in_ready %b out_valid %b required 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_div_cache();
    int acc, oc, s0;
    logic [63:0] e;
    stub_lat = 5;
    s0 = start_cnt;
    issue(1'b0, 1'b0, 1'b1, 64'd100, 64'd7, acc);
    wait_out(oc);
    checks++;
    if (start_cnt !== s0 + 1 || start_cyc !== acc + 1)
      begin errors++; $display("FAIL div_start: count %0d at cycle %0d required %0d at %0d", start_cnt - s0, start_cyc, 1, acc + 1); end
    checks++;
    if (oc !== done_cyc + 1) begin errors++; $display("FAIL div_latency: out cycle %0d required %0d", oc, done_cyc + 1); end
    e = sb.pop_front();
    checks++;
    if (bus.out_result !== e || e !== 64'd14) begin errors++; $display("FAIL div_result: got %h required %h", bus.out_result, 64'd14); end
    tick();
    s0 = start_cnt;
    issue(1'b1, 1'b0, 1'b1, 64'd100, 64'd7, acc);
    wait_out(oc);
    checks++;
    if (oc !== acc + 1) begin errors++; $display("FAIL hit_latency: out cycle %0d required %0d", oc, acc + 1); end
    e = sb.pop_front();
    checks++;
    if (bus.out_result !== e || e !== 64'd2) begin errors++; $display("FAIL hit_result: got %h required %h", bus.out_result, 64'd2); end
    checks++;
    if (start_cnt !== s0) begin errors++; $display("FAIL hit_nostart: starts %0d required 0", start_cnt - s0); end
    tick();
  endtask

  task automatic test_w_ops();
    int acc, oc, s0;
    logic [63:0] e;
    s0 = start_cnt;
    issue(1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1, acc);
    wait_out(oc);
    e = sb.pop_front();
    checks++;
    if (bus.out_result !== 64'hFFFF_FFFF_8000_0000 || e !== bus.out_result)
      begin errors++; $display("FAIL divuw_result: got %h required %h", bus.out_result, 64'hFFFF_FFFF_8000_0000); end
    tick();
    issue(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, acc);
    wait_out(oc);
    e = sb.pop_front();
    checks++;
    if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFFB || e !== bus.out_result)
      begin errors++; $display("FAIL divw_result: got %h required %h", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFB); end
    checks++;
    if (start_cnt !== s0 + 2) begin errors++; $display("FAIL w_starts: got %0d required 2", start_cnt - s0); end
    tick();
  endtask

  task automatic test_special();
    sp_t tbl[6];
    int acc, oc, s0;
    logic [63:0] e;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0005, 64'h0, 64'hFFFF_FFFF_8000_0005};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB};
    s0 = start_cnt;
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].rem, tbl[i].w, tbl[i].sgn, tbl[i].a, tbl[i].b, acc);
      wait_out(oc);
      e = sb.pop_front();
      checks++;
      if (oc !== acc + 1) begin errors++; $display("FAIL special%0d_latency: cycle %0d required %0d", i, oc, acc + 1); end
      checks++;
      if (bus.out_result !== tbl[i].exp || e !== tbl[i].exp)
        begin errors++; $display("FAIL special%0d_result: got %h required %h", i, bus.out_result, tbl[i].exp); end
      tick();
    end
    checks++;
    if (start_cnt !== s0) begin errors++; $display("FAIL special_nostart: starts %0d required 0", start_cnt - s0); end
  endtask

  task automatic test_flush();
    int acc, oc, s0, seen;
    logic [63:0] e;
    stub_lat = 4;
    issue(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3, acc);
    void'(sb.pop_back());
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    checks++;
    if (bus.div_kill !== 1'b1 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL flush_kill: kill %b in_ready %b required 1/0", bus.div_kill, bus.in_ready); end
    tick();
    flush = 1'b0;
    checks++;
    if (bus.div_kill !== 1'b0) begin errors++; $display("FAIL kill_pulse: kill %b required 0", bus.div_kill); end
    seen = 0;
    repeat (8) begin tick(); if (bus.out_valid === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_novalid: out_valid cycles %0d required 0", seen); end
    stub_lat = 5;
    s0 = start_cnt;
    issue(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3, acc);
    wait_out(oc);
    e = sb.pop_front();
    checks++;
    if (start_cnt !== s0 + 1) begin errors++; $display("FAIL flush_miss: starts %0d required 1", start_cnt - s0); end
    checks++;
    if (bus.out_result !== e || e !== 64'd333) begin errors++; $display("FAIL reissue_result: got %h required %h", bus.out_result, 64'd333); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc, oc;
    logic [63:0] r0, e;
    bus.out_ready = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 64'd1000, 64'd3, acc);
    wait_out(oc);
    r0 = bus.out_result;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== r0 || bus.in_ready !== 1'b0)
        begin errors++; $display("FAIL hold%0d: valid %b result %h in_ready %b required 1 %h 0",
                                 i, bus.out_valid, bus.out_result, bus.in_ready, r0); end
      tick();
    end
    bus.in_valid = 1'b1; bus.in_rem = 1'b0; bus.in_w = 1'b0; bus.in_signed = 1'b0;
    bus.in_dividend = 64'd1000; bus.in_divisor = 64'd3;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", bus.in_ready); end
    e = sb.pop_front();
    checks++;
    if (bus.out_result !== e || e !== 64'd1) begin errors++; $display("FAIL b2b_first: got %h required %h", bus.out_result, 64'd1); end
    sb.push_back(ref_div(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3));
    tick();
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== e)
      begin errors++; $display("FAIL b2b_second: valid %b result %h required 1 %h", bus.out_valid, bus.out_result, e); end
    tick();
  endtask

  task automatic test_reset_busy();
    int acc, oc, s0;
    logic [63:0] e;
    stub_lat = 5;
    s0 = start_cnt;
    issue(1'b0, 1'b0, 1'b1, 64'd5000, 64'd9, acc);
    void'(sb.pop_back());
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.div_start, bus.div_kill, bus.div_w, bus.div_signed} !== 6'b0)
      begin errors++; $display("FAIL async_reset_ctrl: got %b required 000000",
            {bus.out_valid, bus.in_ready, bus.div_start, bus.div_kill, bus.div_w, bus.div_signed}); end
    checks++;
    if (bus.out_result !== 64'h0 || bus.div_dividend !== 64'h0 || bus.div_divisor !== 64'h0)
      begin errors++; $display("FAIL async_reset_data: %h %h %h required 0", bus.out_result, bus.div_dividend, bus.div_divisor); end
    tick(); tick();
    reset = 1'b0;
    repeat (8) tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL post_reset_idle: valid %b ready %b required 0/1", bus.out_valid, bus.in_ready); end
    issue(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3, acc);
    wait_out(oc);
    e = sb.pop_front();
    checks++;
    if (start_cnt !== s0 + 2) begin errors++; $display("FAIL reset_cache_miss: starts %0d required 2", start_cnt - s0); end
    checks++;
    if (bus.out_result !== e || e !== 64'd333) begin errors++; $display("FAIL reset_result: got %h required %h", bus.out_result, 64'd333); end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; stub_lat = 5;
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_rem = 1'b0; bus.in_w = 1'b0; bus.in_signed = 1'b0;
    bus.in_dividend = '0; bus.in_divisor = '0; bus.out_ready = 1'b1;
    test_reset();
    test_div_cache();
    test_w_ops();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_busy();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22040931_div_ctrl.md
Name: ysyx_22040931_div_ctrl

Overview:
Sequencing controller in front of the iterative 64-bit divider used by the EX-stage ALU. It accepts DIV/DIVU/REM/REMU and their W variants from the ID→EX handshake and resolves RISC-V special cases (divide-by-zero, signed overflow) in one cycle without starting the divider. It keeps a one-entry result cache so a DIV/REM pair on identical operands costs one divider run. All other cases are started on the divider, which the controller can abort on a pipeline flush.

Parameters:
XLEN, 64, operand/result width
CACHE_EN, 1, 1 enables the one-entry quotient/remainder cache; 0 forces every non-special op to the divider

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush; aborts any in-flight op
in_valid  in  1  request valid (ID side)
in_ready  out  1  controller can accept a request
in_rem  in  1  1 returns remainder, 0 returns quotient
in_w  in  1  32-bit (W) operation
in_signed  in  1  signed operation
in_dividend  in  XLEN  rs1 value
in_divisor  in  XLEN  rs2 value
out_valid  out  1  result valid (EX side)
out_ready  in  1  downstream accepts result
out_result  out  XLEN  final result, sign-extended for W ops
div_start  out  1  one-cycle start pulse to divider
div_kill  out  1  one-cycle abort pulse to divider
div_w  out  1  registered W flag to divider
div_signed  out  1  registered signed flag to divider
div_dividend  out  XLEN  registered dividend
div_divisor  out  XLEN  registered divisor
div_done  in  1  divider completion pulse; quotient and remainder valid that cycle
div_quotient  in  XLEN  divider quotient
div_remainder  in  XLEN  divider remainder

Behaviour:
- States: IDLE, START, BUSY, DONE. Reset → IDLE. All outputs are 0 at reset, and cache valid is 0.
- in_ready = (IDLE) or (DONE and out_ready). An accept happens when in_valid and in_ready are both high. Operands and flags are latched in the accept cycle.
- Classification happens in the accept cycle on the effective operands. For W ops the effective operands are the low 32 bits, sign-extended or zero-extended according to in_signed.
  - Divide-by-zero (effective divisor == 0): quotient = all ones (64 bits); remainder = dividend, sign-extended from bit 31 for W ops.
  - Signed overflow (in_signed, dividend == most-negative, divisor == −1; 32-bit compare for W): quotient = dividend (W: 0xFFFFFFFF80000000); remainder = 0.
  - Cache hit (CACHE_EN, cache valid, all of dividend, divisor, w and signed equal the stored values): use the stored quotient and remainder.
  - Special case or hit: next state DONE. out_valid rises in the cycle after accept (latency 1).
  - Otherwise: next state START.
- START: div_start = 1 for exactly one cycle; next state BUSY. div_* operand outputs stay stable from START until leaving BUSY.
- BUSY: wait for div_done. On div_done, capture quotient and remainder, write the cache (operands, flags, valid = 1), and go to DONE.
- Divider W results are already sign-extended. The controller re-sign-extends bit 31 of the selected result for W ops regardless.
- DONE: out_valid = 1. out_result is held stable until out_ready.
  - out_ready high with no new accept: go to IDLE.
  - out_ready high with a new accept in the same cycle: classify the new request directly (back-to-back, no bubble).
- flush has priority over every other event in all states:
  - Next state IDLE; out_valid drops in the next cycle.
  - If the state is START or BUSY, div_kill pulses in the same cycle and the cache is not written.
  - A div_done arriving in the flush cycle is ignored.
  - No accept occurs in a flush cycle (in_ready is forced low).
- div_done outside BUSY is ignored.
- Cache persists across flushes. It is invalidated only by reset.

Decomposition:
- Shared defines header: state encodings, the DIV_MOST_NEG_64 and DIV_MOST_NEG_32 constants, and the W sign-extend macro.
- One sub-module, ysyx_22040931_div_special: combinational classifier. Inputs: effective operands and flags. Outputs: is_zero, is_ovf, special quotient, special remainder.
- The cache stays inline in the controller.

Test Plan:
- DIV 100/7 with stub divider (done after 5 cycles) → div_start pulses at T+1; out_result = 14 one cycle after done. Then REM on the same operands → out_valid at T+1, result 2, no div_start.
- DIVU x/0 with x = 0x1234 → out_valid at T+1, result 0xFFFFFFFFFFFFFFFF, no div_start. REMUW with dividend 0x00000000_80000005 and divisor 0 → result 0xFFFFFFFF80000005.
- DIV 0x8000000000000000 / −1 → result 0x8000000000000000. REMW with 0x80000000 / 0xFFFFFFFF → result 0. Both without div_start.
- flush asserted 2 cycles into BUSY → div_kill pulses the same cycle; div_done arriving 1 cycle later is ignored; no out_valid. A re-issue of the same op is a cache miss and restarts the divider.
- out_ready held low for 4 cycles in DONE → out_result stable and in_ready low. When out_ready rises with in_valid high, the new op is accepted the same cycle and out_valid goes low for at most 1 cycle.
- Reset asserted asynchronously mid-BUSY → all outputs 0 immediately and state IDLE. A request after reset misses the cache.
